wb_rr_arbiter: RTL and testbench
================================

// Module: wb_rr_arbiter
// PURPOSE
//  Round-robin Wishbone arbiter sharing one slave bus (timer and other peripherals) among N masters.
//  Sits between the CPU/DMA masters and the peripheral decode; one owner at a time, ownership held
//  for the whole cycle (owner cyc high). Bus watchdog aborts transfers the slave never acks.
// PARAMETERS
//  N_MASTERS  2   number of requesting masters (2..8)
//  AW         32  address width
//  DW         32  data width
//  TIMEOUT    16  consecutive unacked stb cycles before abort (>=2)
// PORTS
//  clk        in   1          clock, all logic on rising edge
//  rst        in   1          reset, asynchronous, active-high
//  m_cyc      in   N          per-master cycle request
//  m_stb      in   N          per-master strobe
//  m_we       in   N          per-master write enable
//  m_addr     in   N*AW       packed master addresses, master i at [i*AW +: AW]
//  m_wdata    in   N*DW       packed master write data
//  m_rdata    out  DW         read data, broadcast = s_rdata
//  m_ack      out  N          ack routed to owner only
//  m_err      out  N          one-cycle bus-timeout error to owner
//  s_cyc      out  1          slave cycle
//  s_stb      out  1          slave strobe
//  s_we       out  1          slave write enable
//  s_addr     out  AW         slave address
//  s_wdata    out  DW         slave write data
//  s_rdata    in   DW         slave read data
//  s_ack      in   1          slave ack
//  grant      out  N          one-hot current owner (0 when IDLE/ABORT)
// BEHAVIOUR
//  - Reset: state IDLE, owner=0, last=N_MASTERS-1, wdog=0; grant, m_ack, m_err, s_cyc, s_stb = 0.
//  - States IDLE, OWN, ABORT (registered). s_*/m_ack combinational from state, owner, inputs.
//  - IDLE: s_cyc=s_stb=0. If any m_cyc: owner <= first requester searching last+1, last+2, ...
//    (mod N); -> OWN next cycle. Arbitration latency 1 cycle; no requests -> stay IDLE.
//  - OWN: s_cyc=1, s_stb=m_stb[owner], s_we/s_addr/s_wdata = owner's fields;
//    m_ack[owner]=s_ack, all other m_ack=0; grant[owner]=1.
//    m_cyc[owner]=0 -> IDLE, last<=owner (ack in that cycle still forwarded).
//  - Other masters' cyc/stb ignored while OWN; they wait, never receive ack.
//  - Watchdog: wdog cleared in IDLE/ABORT, on s_ack, or when s_stb=0; else increments.
//    wdog==TIMEOUT-1 with s_stb=1 & s_ack=0 -> next cycle ABORT, m_err[owner]=1 for exactly
//    that cycle, s_cyc=s_stb=0. s_ack in the boundary cycle wins: no error, stays OWN.
//  - ABORT: s_cyc=s_stb=0, grant=0; wait m_cyc[owner]=0 -> IDLE, last<=owner.
//  - Late s_ack in IDLE/ABORT is dropped (no m_ack).
//  - wdog width clog2(TIMEOUT)+1, saturates, never wraps.
//  - Owner dropping cyc same cycle as timeout boundary -> IDLE, no m_err.
//  - rst mid-transfer: immediate return to reset state; s_cyc/s_stb fall asynchronously.
// TESTING
//  1 After reset m_cyc=2'b11 -> cycle 1 grant=01, s_addr=m_addr[0]; m0 drops cyc after ack ->
//    IDLE, next cycle grant=10.
//  2 Both held, alternating single-transfer cycles x4 -> grant sequence 01,10,01,10, no skip.
//  3 m0 owns, m1 requests meanwhile -> m_ack[1]=0 throughout, m1 granted only after m0 drops cyc.
//  4 Slave never acks, TIMEOUT=16, stb high from cycle t -> m_err[owner]=1 only at t+16,
//    s_stb=0 at t+16; ABORT until owner drops cyc.
//  5 s_ack at t+15 (boundary) -> m_ack forwarded, m_err stays 0, state OWN.
//  6 Assert rst mid-OWN with stb high -> s_cyc=s_stb=grant=0 same cycle; after release
//    m_cyc=2'b11 -> master 0 granted first.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter -- round-robin Wishbone arbiter, N masters onto one slave bus.
//
// One master owns the slave for the whole of its cycle (while its cyc stays
// high). Arbitration takes one cycle in IDLE and rotates starting after the
// last owner. A watchdog aborts a strobe the slave never acks. The owner gets
// a one-cycle m_err_o pulse and the bus is released once that owner drops cyc.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   m_cyc_i/m_stb_i/m_we_i   per-master request bits [N_MASTERS-1:0]
//   m_addr_i / m_wdata_i     packed per-master fields, master i at [i*W +: W]
//   m_rdata_o                slave read data broadcast to all masters
//   m_ack_o / m_err_o        per-master ack (owner only) / timeout pulse
//   s_cyc_o..s_wdata_o       muxed slave request
//   s_rdata_i, s_ack_i       slave response
//   grant_o                  one-hot owner, zero outside OWN

// Per-master response routing: a master sees ack/err only while selected.
module wb_rr_lane (
  input  logic sel_i,    // this master is the registered owner
  input  logic own_i,    // arbiter is in OWN
  input  logic err_i,    // timeout pulse cycle
  input  logic s_ack_i,
  output logic grant_o,
  output logic ack_o,
  output logic err_o
);
  assign grant_o = sel_i & own_i;
  assign ack_o   = sel_i & own_i & s_ack_i;
  assign err_o   = sel_i & err_i;
endmodule

module wb_rr_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_MASTERS-1:0]    m_cyc_i,
  input  logic [N_MASTERS-1:0]    m_stb_i,
  input  logic [N_MASTERS-1:0]    m_we_i,
  input  logic [N_MASTERS*AW-1:0] m_addr_i,
  input  logic [N_MASTERS*DW-1:0] m_wdata_i,
  output logic [DW-1:0]           m_rdata_o,
  output logic [N_MASTERS-1:0]    m_ack_o,
  output logic [N_MASTERS-1:0]    m_err_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [AW-1:0]           s_addr_o,
  output logic [DW-1:0]           s_wdata_o,
  input  logic [DW-1:0]           s_rdata_i,
  input  logic                    s_ack_i,
  output logic [N_MASTERS-1:0]    grant_o
);

  localparam int OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [WW-1:0] WDOG_MAX = '1;
  localparam logic [WW-1:0] WDOG_BND = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_ABORT} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_q,  last_d;
  logic [WW-1:0]   wdog_q,  wdog_d;
  logic            err_q,   err_d;   // high for the first ABORT cycle only
  logic [OW-1:0]   pick;

  logic [N_MASTERS-1:0][AW-1:0] addr_v;
  logic [N_MASTERS-1:0][DW-1:0] wdata_v;
  assign addr_v  = m_addr_i;
  assign wdata_v = m_wdata_i;

  logic own;
  assign own = (state_q == S_OWN);

  // Slave side follows the registered owner; outside OWN the bus is quiet.
  assign s_cyc_o   = own;
  assign s_stb_o   = own & m_stb_i[owner_q];
  assign s_we_o    = own & m_we_i[owner_q];
  assign s_addr_o  = addr_v[owner_q];
  assign s_wdata_o = wdata_v[owner_q];
  assign m_rdata_o = s_rdata_i;

  // Rotating search: first requester after the last owner, wrapping mod N.
  always_comb begin
    int idx;
    logic found;
    pick  = last_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      idx = (int'(last_q) + i) % N_MASTERS;
      if (!found && m_cyc_i[idx]) begin
        pick  = OW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wdog_d  = '0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|m_cyc_i) begin
          owner_d = pick;
          state_d = S_OWN;
        end
      end
      S_OWN: begin
        // Owner releasing the bus beats a same-cycle timeout; an ack in the
        // boundary cycle also beats it (the stb is no longer unacked).
        if (!m_cyc_i[owner_q]) begin
          state_d = S_IDLE;
          last_d  = owner_q;
        end else if (s_stb_o && !s_ack_i && wdog_q == WDOG_BND) begin
          state_d = S_ABORT;
          err_d   = 1'b1;
        end
        if (s_stb_o && !s_ack_i)
          wdog_d = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + 1'b1;
      end
      S_ABORT: begin
        if (!m_cyc_i[owner_q]) begin
          state_d = S_IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= OW'(N_MASTERS - 1);
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_lane
    wb_rr_lane u_lane (
      .sel_i   (owner_q == OW'(i)),
      .own_i   (own),
      .err_i   (err_q),
      .s_ack_i (s_ack_i),
      .grant_o (grant_o[i]),
      .ack_o   (m_ack_o[i]),
      .err_o   (m_err_o[i])
    );
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (2 masters, TIMEOUT=16). Stimulus pushes
// the expected outputs for the current cycle; a negedge monitor pops and
// compares them.
module tb_wb_rr_arbiter;
  localparam int N = 2, AW = 32, DW = 32, TO = 16;
  localparam logic [AW-1:0] A0 = 32'h1000_0010, A1 = 32'h2000_0020;

  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] m_cyc = '0, m_stb = '0, m_we = '0;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata, s_wdata, s_rdata = 32'hCAFE_F00D;
  logic [N-1:0] m_ack, m_err, grant;
  logic s_cyc, s_stb, s_we, s_ack = 1'b0;
  logic [AW-1:0] s_addr;

  assign m_addr  = {A1, A0};
  assign m_wdata = {32'hBBBB_0001, 32'hAAAA_0000};

  wb_rr_arbiter #(.N_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_rdata_o(m_rdata),
    .m_ack_o(m_ack), .m_err_o(m_err), .s_cyc_o(s_cyc), .s_stb_o(s_stb),
    .s_we_o(s_we), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_rdata_i(s_rdata), .s_ack_i(s_ack), .grant_o(grant)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic [N-1:0] g, a, e;
    logic        sc, ss, ac;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;

  task automatic chk(string nm, logic [N-1:0] g, logic [N-1:0] a, logic [N-1:0] e,
                     logic sc, logic ss, logic ac = 1'b0, logic [AW-1:0] ad = '0);
    exp_t x;
    x.cyc = cyc_cnt; x.name = nm; x.g = g; x.a = a; x.e = e;
    x.sc = sc; x.ss = ss; x.ac = ac; x.addr = ad;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Monitor: compares every expectation stamped for the current cycle.
  exp_t m;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      m = q.pop_front();
      checks++;
      if (m.cyc < cyc_cnt) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", m.name, m.cyc, cyc_cnt);
      end else if (grant !== m.g || m_ack !== m.a || m_err !== m.e || s_cyc !== m.sc ||
                   s_stb !== m.ss || (m.ac && s_addr !== m.addr)) begin
        errors++;
        $display("FAIL %s @%0d: got grant=%b ack=%b err=%b cyc=%b stb=%b addr=%h, want grant=%b ack=%b err=%b cyc=%b stb=%b addr=%h",
                 m.name, cyc_cnt, grant, m_ack, m_err, s_cyc, s_stb, s_addr,
                 m.g, m.a, m.e, m.sc, m.ss, m.ac ? m.addr : s_addr);
      end
    end
  end

  // One single-beat transfer by owner o, then release; both masters keep requesting.
  task automatic do_xfer(int o, string tag);
    logic [N-1:0] b;
    b = 2'b01 << o;
    m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b1;
    chk({tag, "_ack"}, b, b, 2'b00, 1'b1, 1'b1);
    tick();
    s_ack = 1'b0; m_cyc = 2'b11 & ~b; m_stb = m_cyc;
    chk({tag, "_drop"}, b, 2'b00, 2'b00, 1'b1, 1'b0);
    tick();
    m_cyc = 2'b11; m_stb = 2'b11;
    chk({tag, "_idle"}, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    // Reset
    tick(); tick();
    chk("reset", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    rst = 1'b0;

    // 1: both request after reset, master 0 first
    m_cyc = 2'b11; m_stb = 2'b11;
    chk("t1_idle", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    s_ack = 1'b1;
    chk("t1_grant0", 2'b01, 2'b01, 2'b00, 1'b1, 1'b1, 1'b1, A0);
    tick();
    s_ack = 1'b0; m_cyc = 2'b10; m_stb = 2'b10;
    chk("t1_drop0", 2'b01, 2'b00, 2'b00, 1'b1, 1'b0);
    tick();
    chk("t1_idle2", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    chk("t1_grant1", 2'b10, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, A1);
    tick();

    // 2: alternating ownership with both held
    do_xfer(1, "t2_pre");
    do_xfer(0, "t2_x0");
    do_xfer(1, "t2_x1");
    do_xfer(0, "t2_x2");
    do_xfer(1, "t2_x3");

    // 3: master 0 owns, master 1 waits and never sees an ack
    m_cyc = 2'b11; m_stb = 2'b11;
    for (int k = 0; k < 3; k++) begin
      s_ack = (k != 1);
      chk("t3_hold", 2'b01, s_ack ? 2'b01 : 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, A0);
      tick();
    end
    s_ack = 1'b0; m_cyc = 2'b10; m_stb = 2'b10;
    chk("t3_drop0", 2'b01, 2'b00, 2'b00, 1'b1, 1'b0);
    tick();
    chk("t3_idle", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    chk("t3_grant1", 2'b10, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, A1);
    tick();
    m_cyc = 2'b00; m_stb = 2'b00;
    chk("t3_end", 2'b10, 2'b00, 2'b00, 1'b1, 1'b0);
    tick();

    // 4: slave never acks -> abort at t+16
    m_cyc = 2'b01; m_stb = 2'b01;
    chk("t4_idle", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < TO; k++) begin
      chk("t4_wait", 2'b01, 2'b00, 2'b00, 1'b1, 1'b1);
      tick();
    end
    chk("t4_err", 2'b00, 2'b00, 2'b01, 1'b0, 1'b0);
    tick();
    s_ack = 1'b1;
    chk("t4_late_ack", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
    chk("t4_abort_rel", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    chk("t4_idle_after", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();

    // 5: ack in the boundary cycle wins over the timeout
    m_cyc = 2'b01; m_stb = 2'b01;
    tick();
    for (int k = 0; k < TO - 1; k++) tick();
    s_ack = 1'b1;
    chk("t5_bnd_ack", 2'b01, 2'b01, 2'b00, 1'b1, 1'b1);
    tick();
    s_ack = 1'b0;
    chk("t5_stay_own", 2'b01, 2'b00, 2'b00, 1'b1, 1'b1);
    tick();
    m_cyc = 2'b00; m_stb = 2'b00;
    chk("t5_rel", 2'b01, 2'b00, 2'b00, 1'b1, 1'b0);
    tick();

    // 5b: owner drops cyc in the boundary cycle -> IDLE, no error
    m_cyc = 2'b01; m_stb = 2'b01;
    tick();
    for (int k = 0; k < TO - 1; k++) tick();
    m_cyc = 2'b00;
    chk("t5b_bnd_drop", 2'b01, 2'b00, 2'b00, 1'b1, 1'b1);
    tick();
    m_stb = 2'b00;
    chk("t5b_no_err", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();

    // 6: asynchronous reset mid-transfer
    m_cyc = 2'b01; m_stb = 2'b01;
    tick();
    chk("t6_own", 2'b01, 2'b00, 2'b00, 1'b1, 1'b1);
    tick();
    rst = 1'b1;
    m_cyc = 2'b11; m_stb = 2'b11;
    chk("t6_async_rst", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    chk("t6_idle", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    chk("t6_grant0", 2'b01, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, A0);
    tick();
    m_cyc = 2'b00; m_stb = 2'b00;
    tick(); tick();

    if (q.size() != 0) begin
      errors += q.size();
      $display("FAIL scoreboard: %0d expectations never compared", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
